// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Queue entries pair each fetched word with its PC.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush, used for both the
// instruction queue and the in-flight request PC queue.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full && !i_flush;
  assign w_do_pop  = i_pop && !w_empty && !i_flush;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= nxt(r_wr);
      if (w_do_pop)  r_rd <= nxt(r_rd);
      if (w_do_push && !w_do_pop)
        r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = w_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, in-order imem requests with credit control,
// instruction queue to decode, and redirect flush/drop tracking.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [31:0]   r_pc;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic [OW-1:0] w_pcq_count;
  logic [31:0]   w_pcq_head;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [31:0]   w_used;
  logic          w_fire;
  logic          w_resp_live;
  logic          w_resp_keep;
  logic          w_pop;
  logic          w_unused_lsb;

  // Live words plus in-flight live requests must fit the queue.
  assign w_used = 32'(w_count) + 32'(r_outst) - 32'(r_drop);

  assign imem_req_valid = !rst && !redirect_valid &&
                          (r_outst < OW'(MAX_OUTST)) &&
                          (w_used < 32'(DEPTH));
  assign imem_req_addr  = r_pc;

  assign w_fire      = imem_req_valid && imem_req_ready;
  assign w_resp_live = imem_resp_valid && (r_outst != '0);
  assign w_resp_keep = w_resp_live && (r_drop == '0) &&
                       !redirect_valid;
  assign w_pop       = dec_valid && dec_ready && !redirect_valid;

  assign w_push_entry = '{instr: imem_resp_data, pc: w_pcq_head};
  assign w_unused_lsb = ^redirect_pc[1:0];

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_iq (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_resp_keep),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  fetch_queue #(
    .DEPTH (MAX_OUTST),
    .W     (32)
  ) u_pcq (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_fire),
    .i_push_data (r_pc),
    .i_pop       (w_resp_live),
    .i_flush     (1'b0),
    .o_count     (w_pcq_count),
    .o_head      (w_pcq_head)
  );

  assign dec_valid = (w_count != '0);
  assign dec_instr = w_head.instr;
  assign dec_pc    = w_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_outst <= '0;
      r_drop  <= '0;
    end else begin
      if (redirect_valid)
        r_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_fire)
        r_pc <= r_pc + 32'(INSTR_BYTES);
      r_outst <= r_outst + OW'(w_fire) - OW'(w_resp_live);
      // Everything still in flight after a redirect is old-path.
      if (redirect_valid)
        r_drop <= r_outst - OW'(w_resp_live);
      else if (w_resp_live && (r_drop != '0))
        r_drop <= r_drop - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (w_count <= CW'(DEPTH));
      assert (r_outst <= OW'(MAX_OUTST));
      assert (r_drop <= r_outst);
      assert (w_pcq_count == r_outst);
      assert (!(w_resp_keep && (w_count == CW'(DEPTH))));
    end
  end

endmodule
